// File: rtl/sid_env_mc.sv
// sid_env_mc: time-multiplexed SID-style ADSR envelope generator.
// One shared update engine serves all voices; each clk_en tick updates the
// voice selected by a round-robin slot counter.
//
// Ports:
//   clk        system clock
//   n_reset    synchronous active-low reset
//   clk_en     processing tick (one voice updated per tick)
//   atk/dcy/stn/rls  per-voice 4-bit attack/decay/sustain/release, voice v at [4v+3:4v]
//   gate       per-voice gate
//   vol        per-voice 8-bit envelope level, voice v at [8v+7:8v]
//   env_state  per-voice 2-bit state, voice v at [2v+1:2v]
//   vol_valid  one-cycle strobe after the tick that processed the last voice
//
// Optional build macro: SID_ENV_ZERO_FREEZE_EN -- a released voice sitting at
// level 00 freezes its LFSR and exponent counter until its gate rises.
//
// state           | meaning
// ----------------+----------------------------------------------
// ATTACK (0)      | level ramps up to FF at the attack rate
// DECAY_SUSTAIN(1)| level ramps down to {stn,stn}, then holds
// RELEASE (2)     | level ramps down to 00, then holds
// illegal (3)     | recovered to RELEASE on the voice's next tick

module sid_env_mc #(
  parameter int VOICES = 3
) (
  input  logic                clk,
  input  logic                n_reset,
  input  logic                clk_en,
  input  logic [4*VOICES-1:0] atk,
  input  logic [4*VOICES-1:0] dcy,
  input  logic [4*VOICES-1:0] stn,
  input  logic [4*VOICES-1:0] rls,
  input  logic [VOICES-1:0]   gate,
  output logic [8*VOICES-1:0] vol,
  output logic [2*VOICES-1:0] env_state,
  output logic                vol_valid
);

  localparam int SW = (VOICES > 1) ? $clog2(VOICES) : 1;
  localparam logic [SW-1:0] LAST_SLOT = SW'(VOICES - 1);

  typedef enum logic [1:0] {
    ST_ATTACK        = 2'd0,
    ST_DECAY_SUSTAIN = 2'd1,
    ST_RELEASE       = 2'd2,
    ST_ILLEGAL       = 2'd3
  } state_t;

  logic [SW-1:0] r_slot;
  state_t        r_state   [VOICES];
  logic [7:0]    r_vol     [VOICES];
  logic [14:0]   r_lfsr    [VOICES];
  logic [4:0]    r_exp_cnt [VOICES];
  logic [4:0]    r_exp_per [VOICES];
  logic          r_vol_valid;

  // fields of the voice currently owning the update engine
  state_t      w_state;
  logic [7:0]  w_vol;
  logic [14:0] w_lfsr;
  logic [4:0]  w_cnt;
  logic [4:0]  w_per;
  logic        w_gate;
  logic [3:0]  w_atk, w_dcy, w_stn, w_rls;

  logic [3:0]  w_nib;
  logic        w_match;
  state_t      w_state_nxt;
  logic [7:0]  w_vol_nxt;
  logic [14:0] w_lfsr_nxt;
  logic [4:0]  w_cnt_nxt;
  logic [4:0]  w_per_nxt;

  function automatic logic [14:0] rate_lut(input logic [3:0] n);
    case (n)
      4'h0:    rate_lut = 15'h007F;
      4'h1:    rate_lut = 15'h3000;
      4'h2:    rate_lut = 15'h1E00;
      4'h3:    rate_lut = 15'h0660;
      4'h4:    rate_lut = 15'h0182;
      4'h5:    rate_lut = 15'h5573;
      4'h6:    rate_lut = 15'h000E;
      4'h7:    rate_lut = 15'h3805;
      4'h8:    rate_lut = 15'h2424;
      4'h9:    rate_lut = 15'h2220;
      4'hA:    rate_lut = 15'h090C;
      4'hB:    rate_lut = 15'h0ECD;
      4'hC:    rate_lut = 15'h010E;
      4'hD:    rate_lut = 15'h23F7;
      4'hE:    rate_lut = 15'h5237;
      default: rate_lut = 15'h64A8;
    endcase
  endfunction

  // voice select mux; a compare per voice avoids indexing past VOICES-1
  always_comb begin
    w_state = ST_RELEASE;
    w_vol   = 8'h00;
    w_lfsr  = 15'h0000;
    w_cnt   = 5'd0;
    w_per   = 5'd0;
    w_gate  = 1'b0;
    w_atk   = 4'h0;
    w_dcy   = 4'h0;
    w_stn   = 4'h0;
    w_rls   = 4'h0;
    for (int v = 0; v < VOICES; v++) begin
      if (r_slot == SW'(v)) begin
        w_state = r_state[v];
        w_vol   = r_vol[v];
        w_lfsr  = r_lfsr[v];
        w_cnt   = r_exp_cnt[v];
        w_per   = r_exp_per[v];
        w_gate  = gate[v];
        w_atk   = atk[4*v +: 4];
        w_dcy   = dcy[4*v +: 4];
        w_stn   = stn[4*v +: 4];
        w_rls   = rls[4*v +: 4];
      end
    end
  end

  always_comb begin
    case (w_state)
      ST_ATTACK:        w_nib = w_atk;
      ST_DECAY_SUSTAIN: w_nib = w_dcy;
      default:          w_nib = w_rls;
    endcase
    w_match = (w_lfsr == rate_lut(w_nib));

    // exponent period follows the piecewise-linear breakpoints of the level
    case (w_vol)
      8'hFF:   w_per_nxt = 5'd1;
      8'h5D:   w_per_nxt = 5'd2;
      8'h36:   w_per_nxt = 5'd4;
      8'h1A:   w_per_nxt = 5'd8;
      8'h0E:   w_per_nxt = 5'd16;
      8'h06:   w_per_nxt = 5'd30;
      8'h00:   w_per_nxt = 5'd1;
      default: w_per_nxt = w_per;
    endcase

    // the count wraps against the period held before this tick
    w_cnt_nxt = (w_cnt == w_per) ? 5'd0 : w_cnt + 5'd1;

    if (w_match)
      w_lfsr_nxt = 15'h7FFF;
    else if ((w_cnt == 5'd0) || (w_state == ST_ATTACK))
      w_lfsr_nxt = {w_lfsr[1] ^ w_lfsr[0], w_lfsr[14:1]};
    else
      w_lfsr_nxt = w_lfsr;

`ifdef SID_ENV_ZERO_FREEZE_EN
    if ((w_state == ST_RELEASE) && (w_vol == 8'h00) && !w_gate) begin
      w_cnt_nxt  = w_cnt;
      w_lfsr_nxt = w_lfsr;
    end
`endif

    w_vol_nxt   = w_vol;
    w_state_nxt = w_state;
    case (w_state)
      ST_ATTACK: begin
        if (w_match) begin
          if (w_vol != 8'hFF) w_vol_nxt = w_vol + 8'd1;
          else                w_state_nxt = ST_DECAY_SUSTAIN;
        end
        // gate drop wins over the move to decay on the same tick
        if (!w_gate) w_state_nxt = ST_RELEASE;
      end
      ST_DECAY_SUSTAIN: begin
        if (w_match && (w_vol > {w_stn, w_stn})) w_vol_nxt = w_vol - 8'd1;
        if (!w_gate) w_state_nxt = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (w_match && (w_vol != 8'h00)) w_vol_nxt = w_vol - 8'd1;
        if (w_gate) w_state_nxt = ST_ATTACK;
      end
      default: w_state_nxt = ST_RELEASE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      r_slot      <= '0;
      r_vol_valid <= 1'b0;
      for (int v = 0; v < VOICES; v++) begin
        r_state[v]   <= ST_RELEASE;
        r_vol[v]     <= 8'h00;
        r_lfsr[v]    <= 15'h7FFF;
        r_exp_cnt[v] <= 5'd0;
        r_exp_per[v] <= 5'd1;
      end
    end else begin
      r_vol_valid <= clk_en && (r_slot == LAST_SLOT);
      if (clk_en) begin
        for (int v = 0; v < VOICES; v++) begin
          if (r_slot == SW'(v)) begin
            r_state[v]   <= w_state_nxt;
            r_vol[v]     <= w_vol_nxt;
            r_lfsr[v]    <= w_lfsr_nxt;
            r_exp_cnt[v] <= w_cnt_nxt;
            r_exp_per[v] <= w_per_nxt;
          end
        end
        r_slot <= (r_slot == LAST_SLOT) ? '0 : r_slot + 1'b1;
      end
    end
  end

  always_comb begin
    vol       = '0;
    env_state = '0;
    for (int v = 0; v < VOICES; v++) begin
      vol[8*v +: 8]       = r_vol[v];
      env_state[2*v +: 2] = r_state[v];
    end
  end

  assign vol_valid = r_vol_valid;

endmodule
